// File: rtl/move_sequencer_pkg.sv
// Shared constants, state encoding and step helper for the move sequencer.
package move_sequencer_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned TCNT_W  = 10;

    // Playfield bounds and start position (block centre, pixels)
    localparam int unsigned PF_X_START = 324;
    localparam int unsigned PF_Y_START = 415;
    localparam int unsigned PF_X_MIN   = 316;
    localparam int unsigned PF_X_MAX   = 611;
    localparam int unsigned PF_Y_MIN   = 127;
    localparam int unsigned PF_Y_MAX   = 422;
    localparam int unsigned PF_STEP    = 1;
    localparam int unsigned PF_TIMEOUT = 1023;

    // 12-bit RGB colours shared with the renderer
    localparam logic [11:0] COLOR_BG     = 12'h000;
    localparam logic [11:0] COLOR_WALL   = 12'h00F;
    localparam logic [11:0] COLOR_PLAYER = 12'hFF0;
    localparam logic [11:0] COLOR_COIN   = 12'hFD0;
    localparam logic [11:0] COLOR_FINISH = 12'h0F0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_PROBE = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    // Move one coordinate by step in the given direction and clamp to [lo, hi]
    function automatic logic [COORD_W-1:0] step_clamp(
        input logic [COORD_W-1:0] pos,
        input logic               inc,
        input logic [2:0]         step,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        logic [COORD_W:0] t;
        if (inc) begin
            t = {1'b0, pos} + (COORD_W+1)'(step);
        end else if ({1'b0, pos} < (COORD_W+1)'(step)) begin
            t = '0;
        end else begin
            t = {1'b0, pos} - (COORD_W+1)'(step);
        end
        if (t < {1'b0, lo}) begin
            t = {1'b0, lo};
        end else if (t > {1'b0, hi}) begin
            t = {1'b0, hi};
        end
        return t[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/move_sequencer_step_calc.sv
// Direction priority, step and clamp: proposes the next block centre.
module move_sequencer_step_calc
    import move_sequencer_pkg::*;
#(
    parameter int unsigned X_MIN = PF_X_MIN,
    parameter int unsigned X_MAX = PF_X_MAX,
    parameter int unsigned Y_MIN = PF_Y_MIN,
    parameter int unsigned Y_MAX = PF_Y_MAX,
    parameter int unsigned STEP  = PF_STEP
) (
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               Up,
    input  logic               Down,
    input  logic               Left,
    input  logic               Right,
    output logic [COORD_W-1:0] xprobe_c,
    output logic [COORD_W-1:0] yprobe_c,
    output logic               move_c
);

    // Right > Left > Up > Down; only one axis moves. Up is toward smaller y.
    always_comb begin
        xprobe_c = xpos;
        yprobe_c = ypos;
        if (Right) begin
            xprobe_c = step_clamp(xpos, 1'b1, 3'(STEP), COORD_W'(X_MIN), COORD_W'(X_MAX));
        end else if (Left) begin
            xprobe_c = step_clamp(xpos, 1'b0, 3'(STEP), COORD_W'(X_MIN), COORD_W'(X_MAX));
        end else if (Up) begin
            yprobe_c = step_clamp(ypos, 1'b0, 3'(STEP), COORD_W'(Y_MIN), COORD_W'(Y_MAX));
        end else if (Down) begin
            yprobe_c = step_clamp(ypos, 1'b1, 3'(STEP), COORD_W'(Y_MIN), COORD_W'(Y_MAX));
        end
        move_c = (xprobe_c != xpos) || (yprobe_c != ypos);
    end

endmodule

// File: rtl/move_sequencer.sv
// Player block move sequencer: proposes a step, waits for the renderer's
// collision probe, then commits or rejects it and tracks coins/finish.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int unsigned X_START = PF_X_START,
    parameter int unsigned Y_START = PF_Y_START,
    parameter int unsigned X_MIN   = PF_X_MIN,
    parameter int unsigned X_MAX   = PF_X_MAX,
    parameter int unsigned Y_MIN   = PF_Y_MIN,
    parameter int unsigned Y_MAX   = PF_Y_MAX,
    parameter int unsigned STEP    = PF_STEP,
    parameter int unsigned TIMEOUT = PF_TIMEOUT
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               move_tick,
    input  logic               Up,
    input  logic               Down,
    input  logic               Left,
    input  logic               Right,
    input  logic               probe_done,
    input  logic               probe_wall,
    input  logic               probe_coin,
    input  logic               probe_finish,
    output logic               probe_req,
    output logic [COORD_W-1:0] xprobe,
    output logic [COORD_W-1:0] yprobe,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic [SCORE_W-1:0] score,
    output logic               done,
    output logic               busy
);

    state_t              state;
    logic [TCNT_W-1:0]   tcnt;
    logic [COORD_W-1:0]  xprobe_c;
    logic [COORD_W-1:0]  yprobe_c;
    logic                move_c;

    move_sequencer_step_calc #(
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX),
        .STEP  (STEP)
    ) u_step_calc (
        .xpos     (xpos),
        .ypos     (ypos),
        .Up       (Up),
        .Down     (Down),
        .Left     (Left),
        .Right    (Right),
        .xprobe_c (xprobe_c),
        .yprobe_c (yprobe_c),
        .move_c   (move_c)
    );

    // Probe/commit FSM with timeout; every output is a register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            probe_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            score     <= '0;
            xpos      <= COORD_W'(X_START);
            ypos      <= COORD_W'(Y_START);
            xprobe    <= COORD_W'(X_START);
            yprobe    <= COORD_W'(Y_START);
        end else begin
            case (state)
                S_IDLE: begin
                    if (move_tick && move_c) begin
                        xprobe    <= xprobe_c;
                        yprobe    <= yprobe_c;
                        tcnt      <= '0;
                        probe_req <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (probe_done && !probe_wall) begin
                        // Commit; xprobe already equals the new position
                        xpos      <= xprobe;
                        ypos      <= yprobe;
                        probe_req <= 1'b0;
                        busy      <= 1'b0;
                        if (probe_coin && (score != '1)) begin
                            score <= score + SCORE_W'(1);
                        end
                        if (probe_finish) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (probe_done || (tcnt == TCNT_W'(TIMEOUT - 1))) begin
                        // Wall hit or renderer never answered: drop the probe
                        xprobe    <= xpos;
                        yprobe    <= ypos;
                        probe_req <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                S_DONE: begin
                    probe_req <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    probe_req <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: expected probes are queued at the
// move request and compared when probe_req rises.
module tb_move_sequencer;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic       clk = 1'b0;
    logic       Reset, move_tick, Up, Down, Left, Right;
    logic       probe_done, probe_wall, probe_coin, probe_finish;
    logic       probe_req, done, busy;
    logic [9:0] xprobe, yprobe, xpos, ypos;
    logic [3:0] score;

    int checks   = 0;
    int failures = 0;
    int mx, my, mscore, mdone;
    exp_t q[$];

    move_sequencer dut (
        .clk          (clk),
        .Reset        (Reset),
        .move_tick    (move_tick),
        .Up           (Up),
        .Down         (Down),
        .Left         (Left),
        .Right        (Right),
        .probe_done   (probe_done),
        .probe_wall   (probe_wall),
        .probe_coin   (probe_coin),
        .probe_finish (probe_finish),
        .probe_req    (probe_req),
        .xprobe       (xprobe),
        .yprobe       (yprobe),
        .xpos         (xpos),
        .ypos         (ypos),
        .score        (score),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        mx = 324; my = 415; mscore = 0; mdone = 0;
        q.delete();
    endtask

    // Independent model of the proposed position
    task automatic model_probe(input bit r, l, u, d, output int nx, output int ny);
        nx = mx; ny = my;
        if (r)      nx = (mx + 1 > 611) ? 611 : mx + 1;
        else if (l) nx = (mx - 1 < 316) ? 316 : mx - 1;
        else if (u) ny = (my - 1 < 127) ? 127 : my - 1;
        else if (d) ny = (my + 1 > 422) ? 422 : my + 1;
    endtask

    // One move request with the renderer answering immediately
    task automatic do_move(input bit r, l, u, d, wall, coin, fin);
        int   nx, ny;
        bit   moving;
        exp_t e;
        model_probe(r, l, u, d, nx, ny);
        moving = ((nx != mx) || (ny != my)) && (mdone == 0);
        if (moving) q.push_back({10'(nx), 10'(ny)});
        Right = r; Left = l; Up = u; Down = d; move_tick = 1'b1;
        tick();
        Right = 0; Left = 0; Up = 0; Down = 0; move_tick = 1'b0;
        if (moving) begin
            checks++;
            if (probe_req !== 1'b1) begin
                failures++;
                $display("FAIL probe_req_rise: got %b expected 1", probe_req);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (xprobe !== e.x || yprobe !== e.y) begin
                    failures++;
                    $display("FAIL probe_pos: got %0d,%0d expected %0d,%0d", xprobe, yprobe, e.x, e.y);
                end
            end
            probe_done = 1'b1; probe_wall = wall; probe_coin = coin; probe_finish = fin;
            tick();
            probe_done = 1'b0; probe_wall = 0; probe_coin = 0; probe_finish = 0;
            if (!wall) begin
                mx = nx; my = ny;
                if (coin) mscore = (mscore < 15) ? mscore + 1 : 15;
                if (fin) mdone = 1;
            end
            checks++;
            if (probe_req !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL probe_exit: got req=%b busy=%b expected 0,0", probe_req, busy);
            end
        end else begin
            checks++;
            if (probe_req !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL no_probe: got req=%b busy=%b expected 0,0", probe_req, busy);
            end
        end
        checks++;
        if (xpos !== 10'(mx) || ypos !== 10'(my) || score !== 4'(mscore) || done !== 1'(mdone)) begin
            failures++;
            $display("FAIL commit_state: got %0d,%0d s=%0d d=%b expected %0d,%0d s=%0d d=%0d",
                     xpos, ypos, score, done, mx, my, mscore, mdone);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (xpos !== 10'd324 || ypos !== 10'd415 || xprobe !== 10'd324 || yprobe !== 10'd415 ||
            score !== 4'd0 || done !== 1'b0 || probe_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got x=%0d y=%0d xp=%0d yp=%0d s=%0d d=%b r=%b b=%b expected 324,415,324,415,0,0,0,0",
                     xpos, ypos, xprobe, yprobe, score, done, probe_req, busy);
        end
    endtask

    task automatic test_right_commit();
        do_reset();
        do_move(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (xpos !== 10'd325) begin
            failures++;
            $display("FAIL right_commit: got xpos=%0d expected 325", xpos);
        end
    endtask

    task automatic test_wall_reject();
        do_move(0, 0, 1, 0, 1, 1, 0);
        checks++;
        if (ypos !== 10'd415 || score !== 4'd0 || yprobe !== 10'd415) begin
            failures++;
            $display("FAIL wall_reject: got ypos=%0d score=%0d yprobe=%0d expected 415,0,415", ypos, score, yprobe);
        end
    endtask

    task automatic test_priority();
        do_reset();
        do_move(1, 0, 1, 0, 0, 0, 0);
        do_move(0, 1, 0, 1, 0, 0, 0);
        do_move(0, 0, 1, 1, 0, 0, 0);
        do_move(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_ignored_inputs();
        // Tick without a direction and a stray probe_done while idle
        move_tick = 1'b1;
        tick();
        move_tick = 1'b0;
        checks++;
        if (probe_req !== 1'b0) begin
            failures++;
            $display("FAIL tick_no_dir: got probe_req=%b expected 0", probe_req);
        end
        probe_done = 1'b1; probe_coin = 1'b1; probe_finish = 1'b1;
        tick();
        probe_done = 1'b0; probe_coin = 1'b0; probe_finish = 1'b0;
        tick();
        checks++;
        if (xpos !== 10'(mx) || score !== 4'(mscore) || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_probe_done: got x=%0d s=%0d d=%b expected %0d,%0d,0", xpos, score, done, mx, mscore);
        end
    endtask

    task automatic test_timeout();
        int   cnt;
        exp_t e;
        do_reset();
        q.push_back({10'd325, 10'd415});
        Right = 1'b1; move_tick = 1'b1;
        tick();
        Right = 1'b0; move_tick = 1'b0;
        checks++;
        if (probe_req !== 1'b1) begin
            failures++;
            $display("FAIL timeout_start: got probe_req=%b expected 1", probe_req);
        end
        e = q.pop_front();
        checks++;
        if (xprobe !== e.x || yprobe !== e.y) begin
            failures++;
            $display("FAIL timeout_probe: got %0d,%0d expected %0d,%0d", xprobe, yprobe, e.x, e.y);
        end
        cnt = 0;
        while (probe_req === 1'b1 && cnt < 2000) begin
            // A tick arriving mid-probe must be dropped
            move_tick = (cnt == 10);
            Left = (cnt == 10);
            tick();
            cnt++;
        end
        move_tick = 1'b0; Left = 1'b0;
        checks++;
        if (cnt != 1023) begin
            failures++;
            $display("FAIL timeout_len: got %0d cycles expected 1023", cnt);
        end
        tick();
        checks++;
        if (xpos !== 10'd324 || xprobe !== 10'd324 || busy !== 1'b0 || probe_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_reject: got x=%0d xp=%0d b=%b r=%b expected 324,324,0,0", xpos, xprobe, busy, probe_req);
        end
    endtask

    task automatic test_coin_saturate();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0) do_move(1, 0, 0, 0, 0, 1, 0);
            else            do_move(0, 1, 0, 0, 0, 1, 0);
        end
        checks++;
        if (score !== 4'd15) begin
            failures++;
            $display("FAIL score_saturate: got %0d expected 15", score);
        end
    endtask

    task automatic test_xmax_clamp();
        do_reset();
        while (mx < 611) do_move(1, 0, 0, 0, 0, 0, 0);
        do_move(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (xpos !== 10'd611 || probe_req !== 1'b0) begin
            failures++;
            $display("FAIL xmax_clamp: got x=%0d r=%b expected 611,0", xpos, probe_req);
        end
    endtask

    task automatic test_coin_finish();
        do_reset();
        do_move(1, 0, 0, 0, 0, 1, 1);
        checks++;
        if (done !== 1'b1 || score !== 4'd1 || xpos !== 10'd325) begin
            failures++;
            $display("FAIL coin_finish: got d=%b s=%0d x=%0d expected 1,1,325", done, score, xpos);
        end
        do_move(1, 0, 0, 0, 0, 0, 0);
        probe_done = 1'b1; probe_coin = 1'b1;
        tick();
        probe_done = 1'b0; probe_coin = 1'b0;
        checks++;
        if (xpos !== 10'd325 || score !== 4'd1 || done !== 1'b1 || probe_req !== 1'b0) begin
            failures++;
            $display("FAIL done_hold: got x=%0d s=%0d d=%b r=%b expected 325,1,1,0", xpos, score, done, probe_req);
        end
        do_reset();
        checks++;
        if (xpos !== 10'd324 || ypos !== 10'd415 || score !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL done_reset: got %0d,%0d s=%0d d=%b expected 324,415,0,0", xpos, ypos, score, done);
        end
    endtask

    task automatic test_reset_mid_probe();
        do_reset();
        do_move(0, 0, 1, 0, 0, 0, 0);
        Left = 1'b1; move_tick = 1'b1;
        tick();
        Left = 1'b0; move_tick = 1'b0;
        checks++;
        if (probe_req !== 1'b1 || xprobe !== 10'd323) begin
            failures++;
            $display("FAIL mid_probe_setup: got r=%b xp=%0d expected 1,323", probe_req, xprobe);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (probe_req !== 1'b0 || busy !== 1'b0 || xpos !== 10'd324 || ypos !== 10'd415 ||
            xprobe !== 10'd324 || yprobe !== 10'd415 || score !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_probe: got r=%b b=%b x=%0d y=%0d xp=%0d yp=%0d s=%0d d=%b",
                     probe_req, busy, xpos, ypos, xprobe, yprobe, score, done);
        end
        mx = 324; my = 415; mscore = 0; mdone = 0;
        // A late probe_done from the aborted probe must not commit
        probe_done = 1'b1;
        tick();
        probe_done = 1'b0;
        checks++;
        if (xpos !== 10'd324 || ypos !== 10'd415) begin
            failures++;
            $display("FAIL late_probe_done: got %0d,%0d expected 324,415", xpos, ypos);
        end
    endtask

    initial begin
        Reset = 1'b1; move_tick = 0; Up = 0; Down = 0; Left = 0; Right = 0;
        probe_done = 0; probe_wall = 0; probe_coin = 0; probe_finish = 0;
        tick();
        test_reset();
        test_right_commit();
        test_wall_reject();
        test_priority();
        test_ignored_inputs();
        test_timeout();
        test_coin_saturate();
        test_xmax_clamp();
        test_coin_finish();
        test_reset_mid_probe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
